// File: rtl/preem_filter.sv
// Pre-emphasis filter y[n] = x[n] - (coef * x[n-1]) / 2^COEF_W, built around a bit-serial shift-add multiplier.
// Optional macro PREEM_SAT_EN clamps the result to DATA_W range and adds the sat_flag output.
module preem_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COEF_W-1:0]        coef,
    input  logic                     bypass,
    output logic [DATA_W:0]          out_data,
`ifdef PREEM_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     out_en
);

    localparam int ACC_W = DATA_W + COEF_W;
    localparam int CNT_W = $clog2(COEF_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEF_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUB  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   x_prev_q, x_prev_d;
    logic [DATA_W-1:0]   x_cur_q, x_cur_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COEF_W-1:0]   coef_q, coef_d;
    logic                bypass_q, bypass_d;
    logic [DATA_W:0]     out_data_q, out_data_d;
    logic                out_en_q, out_en_d;
    logic [ACC_W-1:0]    addend;
    logic [DATA_W:0]     x_ext;
    logic [DATA_W:0]     acc_hi;
    logic [DATA_W:0]     result;
`ifdef PREEM_SAT_EN
    localparam logic [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
    logic                sat_q, sat_d;
`endif

    // coef_q shifts right each MUL cycle, so bit 0 is always coef bit cnt.
    // Taking the top DATA_W bits of acc with its sign bit is the floor division by 2^COEF_W.
    always_comb begin
        state_d    = state_q;
        x_prev_d   = x_prev_q;
        x_cur_d    = x_cur_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        coef_d     = coef_q;
        bypass_d   = bypass_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
`ifdef PREEM_SAT_EN
        sat_d      = 1'b0;
`endif
        addend = {{COEF_W{x_prev_q[DATA_W-1]}}, x_prev_q} << cnt_q;
        x_ext  = {x_cur_q[DATA_W-1], x_cur_q};
        acc_hi = {acc_q[ACC_W-1], acc_q[ACC_W-1:COEF_W]};
        result = bypass_q ? x_ext : (x_ext - acc_hi);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_cur_d  = in_data;
                    coef_d   = coef;
                    bypass_d = bypass;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (coef_q[0]) begin
                    acc_d = acc_q + addend;
                end
                coef_d = coef_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                out_data_d = result;
`ifdef PREEM_SAT_EN
                if ($signed(result) > $signed(SAT_MAX)) begin
                    out_data_d = SAT_MAX;
                    sat_d      = 1'b1;
                end else if ($signed(result) < $signed(SAT_MIN)) begin
                    out_data_d = SAT_MIN;
                    sat_d      = 1'b1;
                end
`endif
                out_en_d = 1'b1;
                x_prev_d = x_cur_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_prev_q   <= '0;
            x_cur_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            coef_q     <= '0;
            bypass_q   <= 1'b0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
`ifdef PREEM_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_prev_q   <= x_prev_d;
            x_cur_q    <= x_cur_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            coef_q     <= coef_d;
            bypass_q   <= bypass_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
`ifdef PREEM_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign out_data = out_data_q;
    assign out_en   = out_en_q;
`ifdef PREEM_SAT_EN
    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_preem_filter.sv
// Scoreboard testbench for preem_filter: a reference model queues expected results at
// each acceptance and the output monitor pops and compares them when out_en pulses.
module tb_preem_filter;

   localparam int DATA_W = 16;
   localparam int COEF_W = 8;
   localparam int LAT    = COEF_W + 1;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] inData;
   logic              inValid;
   logic              inReady;
   logic [COEF_W-1:0] coefIn;
   logic              bypassIn;
   logic [DATA_W:0]   outData;
   logic              outEn;
`ifdef PREEM_SAT_EN
   logic              satFlag;
`endif

   typedef struct {
      int data;
      int sat;
      int cyc;
   } expT;

   expT sbQ[$];
   int  cyc = 0;
   int  errCount = 0;
   int  checkCount = 0;
   int  xPrev = 0;
   int  accCyc;
   int  lastAcc;

   preem_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (inData),
      .in_valid (inValid),
      .in_ready (inReady),
      .coef     (coefIn),
      .bypass   (bypassIn),
      .out_data (outData),
`ifdef PREEM_SAT_EN
      .sat_flag (satFlag),
`endif
      .out_en   (outEn)
   );

   // free-running clock and a posedge counter used for latency bookkeeping
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // one comparison: counts it and reports any disagreement
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // drives one sample, waits for acceptance and pushes the model result
   task automatic applyStimulus(input int x, input int c, input bit b, output int accAt);
      expT e;
      int  y;
      int  prod;
      int  waited;
      @(negedge clk);
      inData   = DATA_W'(x);
      coefIn   = COEF_W'(c);
      bypassIn = b;
      inValid  = 1'b1;
      waited   = 0;
      while (!inReady && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!inReady) begin
         checkOutput("accept_timeout", 0, 1);
         accAt = -1;
         return;
      end
      accAt = cyc + 1;
      prod  = c * xPrev;
      y     = b ? x : x - (prod >>> COEF_W);
      e.sat = 0;
`ifdef PREEM_SAT_EN
      if (y > 32767) begin
         y = 32767;
         e.sat = 1;
      end else if (y < -32768) begin
         y = -32768;
         e.sat = 1;
      end
`endif
      e.data = y;
      e.cyc  = accAt + LAT;
      sbQ.push_back(e);
      xPrev = x;
      @(posedge clk);
   endtask

   // drops in_valid and waits for all outstanding results
   task automatic drain();
      int waited;
      @(negedge clk);
      inValid = 1'b0;
      waited  = 0;
      while (sbQ.size() != 0 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (sbQ.size() != 0) checkOutput("drain_timeout", sbQ.size(), 0);
   endtask

   // output monitor: every out_en pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && outEn) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_out_en", 1, 0);
         end else begin
            expT e;
            e = sbQ.pop_front();
            checkOutput("out_data", int'($signed(outData)), e.data);
            checkOutput("latency", cyc, e.cyc);
`ifdef PREEM_SAT_EN
            checkOutput("sat_flag", int'(satFlag), e.sat);
`endif
         end
      end
   end

   initial begin
      rst      = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      coefIn   = '0;
      bypassIn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_data", int'(outData), 0);
      checkOutput("reset_out_en", int'(outEn), 0);
      checkOutput("reset_in_ready", int'(inReady), 1);
      rst = 1'b0;

      // first sample after reset sees x_prev = 0, then busy window of 9 cycles
      applyStimulus(1000, 128, 1'b0, accCyc);
      @(negedge clk);
      checkOutput("busy_in_ready", int'(inReady), 0);
      drain();
      applyStimulus(1000, 128, 1'b0, accCyc);
      drain();
      applyStimulus(-1000, 128, 1'b0, accCyc);
      drain();
      applyStimulus(-1000, 128, 1'b0, accCyc);
      drain();

      // floor truncation of a negative product
      applyStimulus(-3, 128, 1'b0, accCyc);
      drain();
      applyStimulus(0, 128, 1'b0, accCyc);
      drain();

      // extremes of the range
      applyStimulus(-32768, 255, 1'b0, accCyc);
      drain();
      applyStimulus(32767, 255, 1'b0, accCyc);
      drain();
      applyStimulus(123, 0, 1'b0, accCyc);
      drain();

      // reset in the middle of the multiply aborts the sample and clears x_prev
      applyStimulus(777, 128, 1'b0, accCyc);
      @(negedge clk);
      inValid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sbQ.delete();
      xPrev = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_out_data", int'(outData), 0);
      checkOutput("midreset_in_ready", int'(inReady), 1);
      repeat (12) @(negedge clk);
      applyStimulus(200, 128, 1'b0, accCyc);
      drain();

      // back-to-back stream; coef changes while busy must not disturb the sample in flight
      applyStimulus(300, 200, 1'b0, lastAcc);
      applyStimulus(-400, 100, 1'b0, accCyc);
      checkOutput("stream_gap1", accCyc - lastAcc, COEF_W + 2);
      lastAcc = accCyc;
      applyStimulus(5000, 243, 1'b1, accCyc);
      checkOutput("stream_gap2", accCyc - lastAcc, COEF_W + 2);
      lastAcc = accCyc;
      applyStimulus(-7000, 243, 1'b0, accCyc);
      checkOutput("stream_gap3", accCyc - lastAcc, COEF_W + 2);
      drain();
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
